spram_word_bridge: RTL and testbench
====================================

Name: spram_word_bridge

Overview:
- Bridges a 32-bit, byte-enabled memory request port onto one 16Kx16 single-port SPRAM (14-bit halfword address, 2-bit halfword write mask, 1-cycle read latency).
- Sits directly upstream of the 16Kx16 SPRAM wrapper: it generates that wrapper's addr/din/write_en and consumes its dout.
- Splits each 32-bit access into low and high halfword phases, skips unused write halves, reassembles read data and returns a single-cycle ack.

Parameters:
- WORD_ADDR_WIDTH, 13, 32-bit word address width; 2^13 words x 4 B = 32 KB, the full SPRAM.
- RAM_ADDR_WIDTH, 14, halfword address width to the SPRAM; must equal WORD_ADDR_WIDTH+1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_req  in  1  request strobe, sampled only when mem_busy=0.
- mem_we  in  1  1=write, 0=read; qualified by mem_req.
- mem_addr  in  WORD_ADDR_WIDTH  32-bit word address.
- mem_wdata  in  32  write data.
- mem_be  in  4  byte enables; bit i covers mem_wdata[8i+7:8i]; ignored for reads.
- mem_rdata  out  32  read data, valid while mem_ack=1 after a read, held until next read completes.
- mem_ack  out  1  one-cycle completion pulse.
- mem_busy  out  1  high while an access is in progress.
- ram_addr  out  RAM_ADDR_WIDTH  to SPRAM addr.
- ram_din  out  16  to SPRAM din.
- ram_write_en  out  2  to SPRAM write_en (bit1 = upper byte).
- ram_dout  in  16  from SPRAM dout, valid one cycle after address presented.

Behaviour:
- Reset (async, any time incl. mid-access): state IDLE; mem_rdata=0, mem_ack=0, mem_busy=0, ram_addr=0, ram_din=0, ram_write_en=0. Aborted access produces no ack; SPRAM contents may hold a partially written word.
- All outputs registered. mem_busy = (state != IDLE).
- States: IDLE, PH_LO, PH_HI, RD_TAIL.
- IDLE, mem_req=1 (cycle 0 = request cycle):
  - Read: go PH_LO; ram_addr={mem_addr,1'b0}; ram_write_en=0.
  - Write, be[1:0]!=0: go PH_LO; ram_addr={mem_addr,0}; ram_din=wdata[15:0]; ram_write_en=be[1:0].
  - Write, be[1:0]==0, be[3:2]!=0: go PH_HI; ram_addr={mem_addr,1}; ram_din=wdata[31:16]; ram_write_en=be[3:2].
  - Write, be==0: stay IDLE, mem_ack=1 next cycle; no SPRAM access.
  - Latch addr, wdata[31:16], be[3:2], we in internal regs.
- PH_LO: read -> PH_HI, ram_addr={addr,1}. Write with be[3:2]!=0 -> PH_HI, drive high half. Write otherwise -> IDLE, ram_write_en=0, mem_ack=1.
- PH_HI: read -> RD_TAIL, capture mem_rdata[15:0]=ram_dout. Write -> IDLE, ram_write_en=0, mem_ack=1.
- RD_TAIL: capture mem_rdata[31:16]=ram_dout, mem_ack=1, -> IDLE.
- Latency (ack cycle index from request cycle 0): read 4; write both halves 3; write single half 2; write be=0 1.
- mem_ack cycle has state IDLE, so a new request in the ack cycle is accepted (back-to-back). mem_req while busy is ignored, not queued.
- ram_write_en is nonzero only in PH_LO/PH_HI of writes. ram_addr/ram_din hold their last value otherwise.
- mem_rdata changes only in PH_HI/RD_TAIL of reads. A read's lower half may change before ack; consumers sample only on ack.

Decomposition:
- Shared package: state enum (IDLE, PH_LO, PH_HI, RD_TAIL, 2-bit encoding), HALF_LO=1'b0 / HALF_HI=1'b1 constants, default address widths.
- No sub-module. The integration top instantiates this bridge plus the SPRAM wrapper.

Test Plan:
- Write addr=0x0005, wdata=0xDEADBEEF, be=4'hF -> ram_addr 0x000A/0x000B with din 0xBEEF/0xDEAD, write_en 2'b11 each; ack cycle 3. Read addr 0x0005 -> ack cycle 4, mem_rdata=0xDEADBEEF.
- Write addr=0x1FFF, be=4'b0100, wdata=0x00AA0000 over existing 0x12345678 -> only PH_HI, ram_addr 0x3FFF, write_en 2'b01, ack cycle 2; readback 0x12AA5678.
- Write be=4'h0 -> ack cycle 1, ram_write_en stays 0 throughout, memory unchanged.
- Back-to-back: read issued in write-ack cycle is accepted. mem_req pulses during busy are ignored, giving exactly one ack per accepted request.
- Reset_n low in PH_HI of a full write -> all outputs 0 immediately, no ack. After release, mem_busy=0 and a new read completes normally.
- Wrap/boundary: addr 0x0000 and 0x1FFF with alternating patterns 0xA5A5A5A5/0x5A5A5A5A -> no aliasing, exact readback.

Source files
------------

// File: rtl/spram_word_bridge_pkg.sv
// Shared types and constants for the 32-bit to 16Kx16 SPRAM word bridge.
// Imported by the bridge interface and the bridge itself.
package spram_word_bridge_pkg;

    localparam int unsigned WORD_ADDR_WIDTH_DEF = 13;
    localparam int unsigned RAM_ADDR_WIDTH_DEF  = 14;

    // Halfword select appended as the SPRAM address LSB
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PH_LO   = 2'd1,
        PH_HI   = 2'd2,
        RD_TAIL = 2'd3
    } state_e;

endpackage

// File: rtl/spram_word_bridge_if.sv
// Signal bundle between a 32-bit requester, the word bridge and the 16Kx16 SPRAM.
// master = requester view, slave = bridge view, ram = SPRAM wrapper view.
interface spram_word_bridge_if
    import spram_word_bridge_pkg::*;
#(
    parameter int unsigned WORD_ADDR_WIDTH = WORD_ADDR_WIDTH_DEF,
    parameter int unsigned RAM_ADDR_WIDTH  = RAM_ADDR_WIDTH_DEF
);

    logic                       mem_req;
    logic                       mem_we;
    logic [WORD_ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]                mem_wdata;
    logic [3:0]                 mem_be;
    logic [31:0]                mem_rdata;
    logic                       mem_ack;
    logic                       mem_busy;

    logic [RAM_ADDR_WIDTH-1:0]  ram_addr;
    logic [15:0]                ram_din;
    logic [1:0]                 ram_write_en;
    logic [15:0]                ram_dout;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack, mem_busy
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack, mem_busy,
        output ram_addr, ram_din, ram_write_en,
        input  ram_dout
    );

    modport ram (
        input  ram_addr, ram_din, ram_write_en,
        output ram_dout
    );

endinterface

// File: rtl/spram_word_bridge.sv
// Splits 32-bit byte-enabled accesses into low/high halfword SPRAM phases,
// skipping unused write halves and reassembling read data behind a one-cycle ack.
module spram_word_bridge
    import spram_word_bridge_pkg::*;
#(
    parameter int unsigned WORD_ADDR_WIDTH = WORD_ADDR_WIDTH_DEF,
    parameter int unsigned RAM_ADDR_WIDTH  = RAM_ADDR_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    spram_word_bridge_if.slave bus
);

    state_e                     state_q, state_d;
    logic [WORD_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]                wdata_hi_q, wdata_hi_d;
    logic [1:0]                 be_hi_q, be_hi_d;
    logic                       we_q, we_d;

    logic [31:0]                rdata_q, rdata_d;
    logic                       ack_q, ack_d;
    logic                       busy_q, busy_d;
    logic [RAM_ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
    logic [15:0]                ram_din_q, ram_din_d;
    logic [1:0]                 ram_we_q, ram_we_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_hi_q <= '0;
            be_hi_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_hi_q <= wdata_hi_d;
            be_hi_q    <= be_hi_d;
            we_q       <= we_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_hi_d = wdata_hi_q;
        be_hi_d    = be_hi_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        ack_d      = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = '0;

        case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    addr_d     = bus.mem_addr;
                    wdata_hi_d = bus.mem_wdata[31:16];
                    be_hi_d    = bus.mem_be[3:2];
                    we_d       = bus.mem_we;
                    if (!bus.mem_we) begin
                        state_d    = PH_LO;
                        ram_addr_d = {bus.mem_addr, HALF_LO};
                    end else if (bus.mem_be[1:0] != 2'b00) begin
                        state_d    = PH_LO;
                        ram_addr_d = {bus.mem_addr, HALF_LO};
                        ram_din_d  = bus.mem_wdata[15:0];
                        ram_we_d   = bus.mem_be[1:0];
                    end else if (bus.mem_be[3:2] != 2'b00) begin
                        state_d    = PH_HI;
                        ram_addr_d = {bus.mem_addr, HALF_HI};
                        ram_din_d  = bus.mem_wdata[31:16];
                        ram_we_d   = bus.mem_be[3:2];
                    end else begin
                        // Empty byte mask: complete immediately, SPRAM untouched
                        ack_d = 1'b1;
                    end
                end
            end
            PH_LO: begin
                if (!we_q) begin
                    state_d    = PH_HI;
                    ram_addr_d = {addr_q, HALF_HI};
                end else if (be_hi_q != 2'b00) begin
                    state_d    = PH_HI;
                    ram_addr_d = {addr_q, HALF_HI};
                    ram_din_d  = wdata_hi_q;
                    ram_we_d   = be_hi_q;
                end else begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                end
            end
            PH_HI: begin
                if (!we_q) begin
                    // Low-half read data arrives one cycle after its address
                    state_d        = RD_TAIL;
                    rdata_d[15:0]  = bus.ram_dout;
                end else begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                end
            end
            RD_TAIL: begin
                state_d        = IDLE;
                rdata_d[31:16] = bus.ram_dout;
                ack_d          = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.mem_rdata    = rdata_q;
    assign bus.mem_ack      = ack_q;
    assign bus.mem_busy     = busy_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_din      = ram_din_q;
    assign bus.ram_write_en = ram_we_q;

endmodule

// File: tb/tb_spram_word_bridge.sv
// Directed bench for spram_word_bridge with a behavioural 16Kx16 SPRAM
// (byte write mask, one-cycle read latency) hung off the ram side.
module tb_spram_word_bridge;

    logic clk;
    logic reset_n;

    spram_word_bridge_if #(.WORD_ADDR_WIDTH(13), .RAM_ADDR_WIDTH(14)) bus ();

    spram_word_bridge #(.WORD_ADDR_WIDTH(13), .RAM_ADDR_WIDTH(14)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ram_mem [16384];

    always @(posedge clk) begin
        if (bus.ram_write_en[0]) ram_mem[bus.ram_addr][7:0]  <= bus.ram_din[7:0];
        if (bus.ram_write_en[1]) ram_mem[bus.ram_addr][15:8] <= bus.ram_din[15:8];
        bus.ram_dout <= ram_mem[bus.ram_addr];
    end

    int errors = 0;
    int checks = 0;

    int          wr_cnt;
    logic [13:0] wr_addr [4];
    logic [15:0] wr_din  [4];
    logic [1:0]  wr_en   [4];

    // Starts at #1 after a rising edge; returns at #1 after the edge that raised ack.
    task automatic do_access(input logic we, input logic [12:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, output int lat, output logic [31:0] rd);
        bus.mem_req   = 1'b1;
        bus.mem_we    = we;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        bus.mem_be    = be;
        lat    = 0;
        wr_cnt = 0;
        @(posedge clk); #1;
        bus.mem_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (bus.ram_write_en != 2'b00) begin
                if (wr_cnt < 4) begin
                    wr_addr[wr_cnt] = bus.ram_addr;
                    wr_din[wr_cnt]  = bus.ram_din;
                    wr_en[wr_cnt]   = bus.ram_write_en;
                end
                wr_cnt++;
            end
            if (bus.mem_ack) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        rd = bus.mem_rdata;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.mem_rdata, bus.mem_ack, bus.mem_busy, bus.ram_addr, bus.ram_din, bus.ram_write_en} !== 66'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdata=%h ack=%b busy=%b addr=%h din=%h we=%b exp all zero",
                     bus.mem_rdata, bus.mem_ack, bus.mem_busy, bus.ram_addr, bus.ram_din, bus.ram_write_en);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_write_read();
        int lat;
        logic [31:0] rd;
        do_access(1'b1, 13'h0005, 32'hDEADBEEF, 4'hF, lat, rd);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL full_write_latency got %0d exp 3", lat); end
        checks++;
        if (wr_cnt !== 2) begin errors++; $display("FAIL full_write_phases got %0d exp 2", wr_cnt); end
        checks++;
        if ({wr_addr[0], wr_din[0], wr_en[0]} !== {14'h000A, 16'hBEEF, 2'b11}) begin
            errors++;
            $display("FAIL full_write_lo got addr=%h din=%h we=%b exp 000a beef 11", wr_addr[0], wr_din[0], wr_en[0]);
        end
        checks++;
        if ({wr_addr[1], wr_din[1], wr_en[1]} !== {14'h000B, 16'hDEAD, 2'b11}) begin
            errors++;
            $display("FAIL full_write_hi got addr=%h din=%h we=%b exp 000b dead 11", wr_addr[1], wr_din[1], wr_en[1]);
        end
        do_access(1'b0, 13'h0005, 32'h0, 4'h0, lat, rd);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL read_latency got %0d exp 4", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got %h exp deadbeef", rd); end
    endtask

    task automatic test_partial_write();
        int lat;
        logic [31:0] rd;
        do_access(1'b1, 13'h1FFF, 32'h12345678, 4'hF, lat, rd);
        do_access(1'b1, 13'h1FFF, 32'h00AA0000, 4'b0100, lat, rd);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL hi_only_latency got %0d exp 2", lat); end
        checks++;
        if ({wr_cnt[3:0], wr_addr[0], wr_din[0], wr_en[0]} !== {4'd1, 14'h3FFF, 16'h00AA, 2'b01}) begin
            errors++;
            $display("FAIL hi_only_phase got n=%0d addr=%h din=%h we=%b exp 1 3fff 00aa 01",
                     wr_cnt, wr_addr[0], wr_din[0], wr_en[0]);
        end
        do_access(1'b0, 13'h1FFF, 32'h0, 4'h0, lat, rd);
        checks++;
        if (rd !== 32'h12AA5678) begin errors++; $display("FAIL hi_only_readback got %h exp 12aa5678", rd); end

        do_access(1'b1, 13'h0005, 32'hFFFF1234, 4'b0011, lat, rd);
        checks++;
        if ({lat[3:0], wr_cnt[3:0], wr_addr[0], wr_en[0]} !== {4'd2, 4'd1, 14'h000A, 2'b11}) begin
            errors++;
            $display("FAIL lo_only_phase got lat=%0d n=%0d addr=%h we=%b exp 2 1 000a 11",
                     lat, wr_cnt, wr_addr[0], wr_en[0]);
        end
        checks++;
        if (rd !== 32'h12AA5678) begin errors++; $display("FAIL rdata_hold got %h exp 12aa5678", rd); end
        do_access(1'b0, 13'h0005, 32'h0, 4'h0, lat, rd);
        checks++;
        if (rd !== 32'hDEAD1234) begin errors++; $display("FAIL lo_only_readback got %h exp dead1234", rd); end
    endtask

    task automatic test_be_zero();
        int lat;
        logic [31:0] rd;
        do_access(1'b1, 13'h0005, 32'hFFFFFFFF, 4'h0, lat, rd);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL be0_latency got %0d exp 1", lat); end
        checks++;
        if (wr_cnt !== 0) begin errors++; $display("FAIL be0_no_write got %0d exp 0", wr_cnt); end
        do_access(1'b0, 13'h0005, 32'h0, 4'h0, lat, rd);
        checks++;
        if (rd !== 32'hDEAD1234) begin errors++; $display("FAIL be0_readback got %h exp dead1234", rd); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] rd;
        do_access(1'b1, 13'h0100, 32'hCAFEF00D, 4'hF, lat, rd);
        do_access(1'b0, 13'h0100, 32'h0, 4'h0, lat, rd);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d exp 4", lat); end
        checks++;
        if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_data got %h exp cafef00d", rd); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        int acks;
        logic [31:0] rd;
        logic [31:0] ack_data;
        do_access(1'b1, 13'h0300, 32'h01234567, 4'hF, lat, rd);
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 13'h0300;
        @(posedge clk); #1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = 32'hFFFFFFFF;
        bus.mem_be    = 4'hF;
        acks     = 0;
        ack_data = '0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) bus.mem_req = 1'b0;
            if (bus.mem_ack) begin
                acks++;
                ack_data = bus.mem_rdata;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (acks !== 1) begin errors++; $display("FAIL busy_ack_count got %0d exp 1", acks); end
        checks++;
        if (ack_data !== 32'h01234567) begin errors++; $display("FAIL busy_read_data got %h exp 01234567", ack_data); end
        do_access(1'b0, 13'h0300, 32'h0, 4'h0, lat, rd);
        checks++;
        if (rd !== 32'h01234567) begin errors++; $display("FAIL busy_ignored_write got %h exp 01234567", rd); end
    endtask

    task automatic test_reset_mid_access();
        int lat;
        int acks;
        logic [31:0] rd;
        do_access(1'b1, 13'h0200, 32'h11112222, 4'hF, lat, rd);
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 13'h0200;
        bus.mem_wdata = 32'h33334444;
        bus.mem_be    = 4'hF;
        @(posedge clk); #1;
        bus.mem_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.mem_busy, bus.ram_addr, bus.ram_write_en} !== {1'b1, 14'h0401, 2'b11}) begin
            errors++;
            $display("FAIL abort_in_ph_hi got busy=%b addr=%h we=%b exp 1 0401 11",
                     bus.mem_busy, bus.ram_addr, bus.ram_write_en);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_rdata, bus.mem_ack, bus.mem_busy, bus.ram_addr, bus.ram_din, bus.ram_write_en} !== 66'd0) begin
            errors++;
            $display("FAIL abort_outputs got rdata=%h ack=%b busy=%b addr=%h din=%h we=%b exp all zero",
                     bus.mem_rdata, bus.mem_ack, bus.mem_busy, bus.ram_addr, bus.ram_din, bus.ram_write_en);
        end
        acks = 0;
        @(posedge clk); #1;
        if (bus.mem_ack) acks++;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.mem_ack) acks++;
        end
        checks++;
        if ({acks[3:0], bus.mem_busy} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL abort_no_ack got acks=%0d busy=%b exp 0 0", acks, bus.mem_busy);
        end
        do_access(1'b0, 13'h0200, 32'h0, 4'h0, lat, rd);
        checks++;
        if ({lat[3:0], rd} !== {4'd4, 32'h11114444}) begin
            errors++;
            $display("FAIL abort_readback got lat=%0d data=%h exp 4 11114444", lat, rd);
        end
    endtask

    task automatic test_boundary();
        int lat;
        logic [31:0] rd;
        logic [31:0] pat [2];
        pat[0] = 32'hA5A5A5A5;
        pat[1] = 32'h5A5A5A5A;
        for (int p = 0; p < 2; p++) begin
            do_access(1'b1, 13'h0000, pat[p], 4'hF, lat, rd);
            do_access(1'b1, 13'h1FFF, pat[1-p], 4'hF, lat, rd);
            do_access(1'b0, 13'h0000, 32'h0, 4'h0, lat, rd);
            checks++;
            if (rd !== pat[p]) begin errors++; $display("FAIL boundary_low pass=%0d got %h exp %h", p, rd, pat[p]); end
            do_access(1'b0, 13'h1FFF, 32'h0, 4'h0, lat, rd);
            checks++;
            if (rd !== pat[1-p]) begin errors++; $display("FAIL boundary_high pass=%0d got %h exp %h", p, rd, pat[1-p]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_be_zero();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_access();
        test_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
